// File: rtl/decode_stage_pipe_pkg.sv
// Shared definitions for the decode stage: RV32I opcodes, immediate formats
// and the per-instruction field bundle carried down the pipeline.
package decode_stage_pipe_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_R,
    FMT_NONE
  } immFmt_e;

  // Width-independent part of a decoded instruction
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } instrFields_t;

  function automatic instrFields_t splitFields(input logic [31:0] instr, input logic illegal);
    instrFields_t f;
    f.opcode  = instr[6:0];
    f.func3   = instr[14:12];
    f.func7   = instr[31:25];
    f.rd      = instr[11:7];
    f.rs1     = instr[19:15];
    f.rs2     = instr[24:20];
    f.illegal = illegal;
    return f;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Instruction-in / decoded-bundle-out bus of the decode stage, including the
// register-file read port, writeback snoop and stall/flush controls.
interface decode_stage_pipe_if #(
  parameter int XLEN = decode_stage_pipe_pkg::XLEN_DEFAULT
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [4:0]      rf_raddr0;
  logic [4:0]      rf_raddr1;
  logic [XLEN-1:0] rf_rdata0;
  logic [XLEN-1:0] rf_rdata1;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            stall;
  logic            flush;
  logic            out_valid;
  logic [6:0]      out_opcode;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  // Fetch / register file / control side
  modport master (
    output in_valid, instr, pc, rf_rdata0, rf_rdata1, wb_we, wb_addr, wb_data, stall, flush,
    input  in_ready, rf_raddr0, rf_raddr1, out_valid, out_opcode, out_func3, out_func7,
           out_rd, out_rs1_data, out_rs2_data, out_imm, out_pc, out_illegal
  );

  // Decode stage side
  modport slave (
    input  in_valid, instr, pc, rf_rdata0, rf_rdata1, wb_we, wb_addr, wb_data, stall, flush,
    output in_ready, rf_raddr0, rf_raddr1, out_valid, out_opcode, out_func3, out_func7,
           out_rd, out_rs1_data, out_rs2_data, out_imm, out_pc, out_illegal
  );
endinterface

// File: rtl/decode_stage_pipe_imm_gen.sv
// Combinational immediate generator: classifies the opcode into an immediate
// format and builds the sign/zero-extended immediate. Unknown opcodes give
// imm = 0 with illegal set.
module decode_stage_pipe_imm_gen
  import decode_stage_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output immFmt_e         fmt,
  output logic            illegal
);

  logic shiftImm;

  // Format classification and immediate assembly
  always_comb begin
    fmt      = FMT_NONE;
    imm      = '0;
    // SLLI/SRLI/SRAI carry shamt plus func7 bits, so they are not sign-extended
    shiftImm = (instr[6:0] == OP_IMM) && ((instr[14:12] == 3'b001) || (instr[14:12] == 3'b101));
    unique case (instr[6:0])
      OP_IMM, JALR, LOAD: fmt = FMT_I;
      STORE:              fmt = FMT_S;
      BRANCH:             fmt = FMT_B;
      AUIPC, LUI:         fmt = FMT_U;
      JAL:                fmt = FMT_J;
      OP:                 fmt = FMT_R;
      default:            fmt = FMT_NONE;
    endcase
    case (fmt)
      FMT_I:   imm = shiftImm ? XLEN'(instr[31:20]) : XLEN'($signed(instr[31:20]));
      FMT_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FMT_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
      FMT_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      default: imm = '0;
    endcase
    illegal = (fmt == FMT_NONE);
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: splits the instruction, reads operands (with writeback
// bypass), and carries the bundle through DEPTH register stages with
// valid/stall/flush control and in-flight operand refresh.
module decode_stage_pipe
  import decode_stage_pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int DEPTH  = 2,
  parameter int FWD_EN = 1
) (
  input logic clk,
  input logic reset,
  decode_stage_pipe_if.slave bus
);

  logic [31:0]     instr;
  logic [4:0]      rs1Num;
  logic [4:0]      rs2Num;
  logic [XLEN-1:0] capImm;
  immFmt_e         capFmt;
  logic            capIllegal;
  logic            unusedFmt;
  logic [XLEN-1:0] capRs1Data;
  logic [XLEN-1:0] capRs2Data;
  instrFields_t    capFields;

  logic            validReg   [DEPTH];
  instrFields_t    fieldsReg  [DEPTH];
  logic [XLEN-1:0] rs1DataReg [DEPTH];
  logic [XLEN-1:0] rs2DataReg [DEPTH];
  logic [XLEN-1:0] immReg     [DEPTH];
  logic [XLEN-1:0] pcReg      [DEPTH];
  logic [XLEN-1:0] rs1Fresh   [DEPTH];
  logic [XLEN-1:0] rs2Fresh   [DEPTH];

  // A writeback to a nonzero register matching rs replaces that operand
  function automatic logic wbHits(input logic [4:0] rs, input logic we, input logic [4:0] addr);
    return (FWD_EN != 0) && we && (addr != 5'd0) && (addr == rs);
  endfunction

  assign instr         = bus.instr;
  assign rs1Num        = instr[19:15];
  assign rs2Num        = instr[24:20];
  assign bus.rf_raddr0 = rs1Num;
  assign bus.rf_raddr1 = rs2Num;
  assign bus.in_ready  = !bus.stall;
  assign capFields     = splitFields(instr, capIllegal);
  // Format is only needed by other users of the generator
  assign unusedFmt     = ^capFmt;

  decode_stage_pipe_imm_gen #(.XLEN(XLEN)) immGen (
    .instr   (instr),
    .imm     (capImm),
    .fmt     (capFmt),
    .illegal (capIllegal)
  );

  // Operand capture: x0 reads zero, a same-cycle writeback beats the register file
  always_comb begin
    capRs1Data = bus.rf_rdata0;
    capRs2Data = bus.rf_rdata1;
    if (rs1Num == 5'd0) capRs1Data = '0;
    else if (wbHits(rs1Num, bus.wb_we, bus.wb_addr)) capRs1Data = bus.wb_data;
    if (rs2Num == 5'd0) capRs2Data = '0;
    else if (wbHits(rs2Num, bus.wb_we, bus.wb_addr)) capRs2Data = bus.wb_data;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gStage
      logic            srcValid;
      instrFields_t    srcFields;
      logic [XLEN-1:0] srcRs1;
      logic [XLEN-1:0] srcRs2;
      logic [XLEN-1:0] srcImm;
      logic [XLEN-1:0] srcPc;

      // This stage's operands with the current writeback folded in
      assign rs1Fresh[gi] = (validReg[gi] && wbHits(fieldsReg[gi].rs1, bus.wb_we, bus.wb_addr))
                            ? bus.wb_data : rs1DataReg[gi];
      assign rs2Fresh[gi] = (validReg[gi] && wbHits(fieldsReg[gi].rs2, bus.wb_we, bus.wb_addr))
                            ? bus.wb_data : rs2DataReg[gi];

      if (gi == 0) begin : gSrcCapture
        assign srcValid  = bus.in_valid;
        assign srcFields = capFields;
        assign srcRs1    = capRs1Data;
        assign srcRs2    = capRs2Data;
        assign srcImm    = capImm;
        assign srcPc     = bus.pc;
      end else begin : gSrcPrev
        assign srcValid  = validReg[gi-1];
        assign srcFields = fieldsReg[gi-1];
        assign srcRs1    = rs1Fresh[gi-1];
        assign srcRs2    = rs2Fresh[gi-1];
        assign srcImm    = immReg[gi-1];
        assign srcPc     = pcReg[gi-1];
      end

      // Stage register: reset clears, flush drops valid, stall holds with refresh, else advance
      always_ff @(posedge clk) begin
        if (reset) begin
          validReg[gi]   <= 1'b0;
          fieldsReg[gi]  <= '0;
          rs1DataReg[gi] <= '0;
          rs2DataReg[gi] <= '0;
          immReg[gi]     <= '0;
          pcReg[gi]      <= '0;
        end else if (bus.flush) begin
          validReg[gi]   <= 1'b0;
        end else if (bus.stall) begin
          rs1DataReg[gi] <= rs1Fresh[gi];
          rs2DataReg[gi] <= rs2Fresh[gi];
        end else begin
          validReg[gi]   <= srcValid;
          fieldsReg[gi]  <= srcFields;
          rs1DataReg[gi] <= srcRs1;
          rs2DataReg[gi] <= srcRs2;
          immReg[gi]     <= srcImm;
          pcReg[gi]      <= srcPc;
        end
      end
    end
  endgenerate

  assign bus.out_valid    = validReg[DEPTH-1];
  assign bus.out_opcode   = fieldsReg[DEPTH-1].opcode;
  assign bus.out_func3    = fieldsReg[DEPTH-1].func3;
  assign bus.out_func7    = fieldsReg[DEPTH-1].func7;
  assign bus.out_rd       = fieldsReg[DEPTH-1].rd;
  assign bus.out_illegal  = fieldsReg[DEPTH-1].illegal;
  assign bus.out_rs1_data = rs1DataReg[DEPTH-1];
  assign bus.out_rs2_data = rs2DataReg[DEPTH-1];
  assign bus.out_imm      = immReg[DEPTH-1];
  assign bus.out_pc       = pcReg[DEPTH-1];

endmodule
